// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer: latches device interrupt edges into a pending vector and
// walks the pipeline through drain, handler entry and eret return.
module exc_ctrl #(
  parameter int DEV_CNT   = 6,
  parameter int DRAIN_MAX = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DEV_CNT-1:0] DevIrq,
  output logic [DEV_CNT-1:0] HWInt,
  output logic [DEV_CNT-1:0] DevAck,
  input  logic               IntReq,
  input  logic               InstValid,
  input  logic               PipeIdle,
  input  logic               EretM,
  output logic               Stall,
  output logic               Flush,
  output logic               EXLSet,
  output logic               EXLClr,
  output logic [1:0]         PCSel,
  output logic [2:0]         IntCode,
  output logic               Timeout,
  output logic               ErrEret
);

  localparam int CW = (DRAIN_MAX < 1) ? 1 : $clog2(DRAIN_MAX + 1);

  typedef enum logic [2:0] {IDLE, DRAIN, ENTER, HANDLER, RETURN} state_t;

  state_t               state, state_nxt;
  logic [DEV_CNT-1:0]   dev_irq_q;
  logic [DEV_CNT-1:0]   rise;
  logic [DEV_CNT-1:0]   ack_vec;
  logic [CW-1:0]        drain_cnt;
  logic                 drain_hit;
  logic [2:0]           prio_code;

  assign rise      = DevIrq & ~dev_irq_q;
  assign drain_hit = (drain_cnt >= CW'(DRAIN_MAX - 1));

  // Lowest pending index wins; 7 flags an interrupt with nothing pending (software SR write).
  always_comb begin
    prio_code = 3'd7;
    for (int i = DEV_CNT - 1; i >= 0; i--) begin
      if (HWInt[i]) prio_code = 3'(i);
    end
  end

  always_comb begin
    for (int i = 0; i < DEV_CNT; i++) begin
      ack_vec[i] = (IntCode == 3'(i));
    end
  end

  // Dropping IntReq during drain aborts even if the pipe just went idle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (IntReq && InstValid) state_nxt = DRAIN;
      DRAIN: begin
        if (!IntReq)                    state_nxt = IDLE;
        else if (PipeIdle || drain_hit) state_nxt = ENTER;
      end
      ENTER:   state_nxt = HANDLER;
      HANDLER: if (EretM) state_nxt = RETURN;
      RETURN:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are registered yet line up with the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      dev_irq_q <= '0;
      HWInt     <= '0;
      DevAck    <= '0;
      drain_cnt <= '0;
      IntCode   <= 3'd0;
      Stall     <= 1'b0;
      Flush     <= 1'b0;
      EXLSet    <= 1'b0;
      EXLClr    <= 1'b0;
      PCSel     <= 2'b00;
      Timeout   <= 1'b0;
      ErrEret   <= 1'b0;
    end else begin
      state     <= state_nxt;
      dev_irq_q <= DevIrq;
      HWInt     <= (HWInt & ~DevAck) | rise;
      Stall     <= (state_nxt == DRAIN) || (state_nxt == ENTER);
      Flush     <= (state_nxt == ENTER) || (state_nxt == RETURN);
      EXLSet    <= (state_nxt == ENTER);
      EXLClr    <= (state_nxt == RETURN);
      PCSel     <= (state_nxt == ENTER)  ? 2'b01 :
                   (state_nxt == RETURN) ? 2'b10 : 2'b00;
      DevAck    <= (state_nxt == ENTER) ? ack_vec : '0;
      if (state == IDLE && state_nxt == DRAIN) begin
        IntCode   <= prio_code;
        drain_cnt <= '0;
      end else if (state == DRAIN && drain_cnt < CW'(DRAIN_MAX)) begin
        drain_cnt <= drain_cnt + 1'b1;
      end
      if (state == DRAIN && IntReq && !PipeIdle && drain_hit) Timeout <= 1'b1;
      if (EretM && (state == IDLE || state == DRAIN)) ErrEret <= 1'b1;
    end
  end

endmodule

// File: doc/exc_ctrl.md
EXC_CTRL -- requirements
Module: exc_ctrl

Interface
REQ-001 Parameter DEV_CNT, default 6: number of hardware interrupt sources; matches the CP0 HWInt width.
REQ-002 Parameter DRAIN_MAX, default 15: maximum number of DRAIN cycles spent waiting for PipeIdle.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 DevIrq  in  DEV_CNT  device interrupt request lines, level.
REQ-006 HWInt  out  DEV_CNT  registered pending vector, driven to CP0 HWInt.
REQ-007 DevAck  out  DEV_CNT  one-hot acknowledge of the serviced source, one-cycle pulse.
REQ-008 IntReq  in  1  CP0 interrupt request (already masked by IM/IE/EXL).
REQ-009 InstValid  in  1  commit stage holds a valid instruction, so EPC is meaningful.
REQ-010 PipeIdle  in  1  no outstanding memory or multi-cycle operation.
REQ-011 EretM  in  1  eret at commit stage.
REQ-012 Stall  out  1  freeze fetch and decode.
REQ-013 Flush  out  1  squash all in-flight instructions.
REQ-014 EXLSet / EXLClr  out  1 each  to CP0; these are never asserted together.
REQ-015 PCSel  out  2  next-PC source: 00 sequential, 01 handler vector, 10 EPC.
REQ-016 IntCode  out  3  index of the serviced source; holds its value until the next entry.
REQ-017 Timeout  out  1  sticky: a drain timeout has occurred.
REQ-018 ErrEret  out  1  sticky: eret was seen while no exception was active.

Function
REQ-019 Each cycle, the block registers DevIrq as DevIrq_q and computes rise = DevIrq & ~DevIrq_q.
REQ-020 A rise bit sets the matching bit of the pending register.
REQ-021 The DevAck bit clears the matching pending bit.
REQ-022 If a set and a clear hit the same bit in the same cycle, the set wins.
REQ-023 HWInt equals the pending register, so HWInt is visible one cycle after the rising edge is sampled.
REQ-024 Priority is lowest index highest: bit 0 beats bit 5.
REQ-025 The FSM has five states: IDLE, DRAIN, ENTER, HANDLER, RETURN. All outputs are Moore outputs decoded from state, except DevAck.
REQ-026 IDLE: all control outputs are 0.
- Go to DRAIN when IntReq && InstValid.
- At that transition, capture the highest-priority pending index into IntCode and clear the drain counter.
REQ-027 DRAIN: Stall=1, and the drain counter increments each cycle.
- Go to ENTER when PipeIdle=1.
- Also go to ENTER when the counter reaches DRAIN_MAX; in that case set Timeout.
- If IntReq drops before either exit, abort to IDLE and release Stall next cycle.
REQ-028 ENTER lasts exactly one cycle: Stall=1, Flush=1, EXLSet=1, PCSel=01, DevAck=onehot(IntCode). The next state is HANDLER.
REQ-029 HANDLER: all controls are 0.
- Go to RETURN on EretM.
- IntReq is ignored in this state; CP0 holds it low through EXL.
REQ-030 RETURN lasts exactly one cycle: Flush=1, EXLClr=1, PCSel=10. The next state is IDLE.
REQ-031 EretM in IDLE or DRAIN has no control effect and sets ErrEret.
REQ-032 EretM asserted together with IntReq in HANDLER: eret wins.
REQ-033 Minimum latency: IntReq sampled at edge N with PipeIdle=1 gives DRAIN at N+1 and ENTER at N+2.
REQ-034 Back-to-back interrupts: after RETURN, the block re-enters DRAIN no earlier than the first IDLE cycle.
REQ-035 The drain counter saturates at DRAIN_MAX and never wraps.
REQ-036 If IntReq is set while the pending vector is zero (a software-written SR case), IntCode=7 and DevAck stays all zeros.

Reset
REQ-037 Reset, sampled at a rising edge, places the block in its initial condition:
- state IDLE;
- pending, DevIrq_q and the drain counter at 0;
- IntCode 0;
- Timeout and ErrEret at 0;
- all outputs 0 on the following cycle.
REQ-038 Reset asserted mid-sequence (DRAIN, ENTER or RETURN) aborts the sequence with no further EXLSet or EXLClr pulse.
REQ-039 A DevIrq line held high through reset release registers as a rise on the first post-reset cycle.

Verification
REQ-040 Basic entry and return:
- Stimulus: DevIrq=000100, IntReq=1, InstValid=1, PipeIdle=1.
- Response: HWInt=000100 one cycle after the edge; ENTER two cycles after IntReq with EXLSet=1, PCSel=01, DevAck=000100, IntCode=2.
- Then: EretM=1 in HANDLER gives one RETURN cycle with EXLClr=1, PCSel=10, followed by IDLE.
REQ-041 Priority:
- Stimulus: DevIrq rises 100001 and 000010 in the same cycle.
- Response: IntCode=0, DevAck=000001; pending keeps 100010.
REQ-042 Drain timeout:
- Stimulus: PipeIdle=0 held, DRAIN_MAX=15.
- Response: exactly 15 cycles with Stall=1, then ENTER, and Timeout=1 sticky.
REQ-043 Abort:
- Stimulus: IntReq drops in the 3rd DRAIN cycle.
- Response: IDLE next cycle, no EXLSet pulse, Stall=0, pending unchanged.
REQ-044 Set/clear collision and stray eret:
- Stimulus: a new rise on bit 2 in the ENTER cycle that acks bit 2.
- Response: pending bit 2 stays 1.
- Stimulus: EretM in IDLE.
- Response: ErrEret=1, no Flush.
REQ-045 Reset in ENTER:
- Stimulus: assert reset during the ENTER cycle.
- Response: every output is 0 on the following cycle, and no EXLClr pulse is ever issued.
